// File: rtl/mdu_hilo_pkg.sv
// Shared opcode/state encodings and default width for the MIPS multiply/divide unit.
package mdu_hilo_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MTX  = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_FIX  = 3'd4
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divide / shift-add multiply iteration datapath; one step per
// cycle while step_i is high, sequenced entirely by mdu_hilo.
module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            mul_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN-1:0] rem_q, quo_q, b_q;
    logic [XLEN-1:0] rem_d, quo_d;
    logic [XLEN:0]   partial, diff, sum;

    // Multiply treats {rem,quo} as the 2*XLEN product register shifting right;
    // divide treats it as the remainder/dividend pair shifting left.
    always_comb begin
        partial = {rem_q, quo_q[XLEN-1]};
        diff    = partial - {1'b0, b_q};
        sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (mul_i) begin
            rem_d = sum[XLEN:1];
            quo_d = {sum[0], quo_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = partial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            rem_q <= '0;
            quo_q <= a_i;
            b_q   <= b_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign rem_o = rem_q;
    assign quo_o = quo_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO registers.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,
    output logic            busy,
    output logic [XLEN-1:0] hi_rdata,
    output logic [XLEN-1:0] lo_rdata
);

    mdu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic [XLEN-1:0]   src1_q, src2_q;
    logic [2:0]        op_q;

    logic              accept, is_arith, in_signed;
    logic              sgn1, sgn2;
    logic [XLEN-1:0]   core_rem, core_quo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign accept    = req_valid && (state_q == ST_IDLE) && !flush;
    assign in_signed = op_is_signed(req_op);
    assign is_arith  = (req_op == OP_MULT) || (req_op == OP_MULTU) ||
                       (req_op == OP_DIV)  || (req_op == OP_DIVU);

    mdu_div_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .load_i (accept && is_arith),
        .step_i ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .mul_i  (state_q == ST_MUL),
        .a_i    (mag(req_src1, in_signed && req_src1[XLEN-1])),
        .b_i    (mag(req_src2, in_signed && req_src2[XLEN-1])),
        .rem_o  (core_rem),
        .quo_o  (core_quo)
    );

    assign sgn1     = op_is_signed(op_q) && src1_q[XLEN-1];
    assign sgn2     = op_is_signed(op_q) && src2_q[XLEN-1];
    assign prod_fix = (sgn1 ^ sgn2) ? -{core_rem, core_quo} : {core_rem, core_quo};
    assign quo_fix  = (sgn1 ^ sgn2) ? -core_quo : core_quo;
    assign rem_fix  = sgn1 ? -core_rem : core_rem;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{sgn1}}, src1_q} * {{XLEN{sgn2}}, src2_q};
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            src1_q <= req_src1;
            src2_q <= req_src2;
            op_q   <= req_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        cnt_q <= CNT_W'(XLEN - 1);
                        case (req_op)
                            OP_MTHI:            hi_q    <= req_src1;
                            OP_MTLO:            lo_q    <= req_src1;
                            OP_MULT, OP_MULTU:  state_q <= ST_MUL;
                            OP_DIV, OP_DIVU:    state_q <= ST_DIV;
                            default:            state_q <= ST_IDLE;
                        endcase
                    end
                end
`ifdef MDU_FAST_MUL_EN
                ST_MUL: begin
                    hi_q    <= fast_prod[2*XLEN-1:XLEN];
                    lo_q    <= fast_prod[XLEN-1:0];
                    state_q <= ST_IDLE;
                end
`else
                ST_MUL: begin
                    if (cnt_q == '0) state_q <= ST_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
`endif
                ST_DIV: begin
                    if (cnt_q == '0) state_q <= ST_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
                        hi_q <= prod_fix[2*XLEN-1:XLEN];
                        lo_q <= prod_fix[XLEN-1:0];
                    end else if (src2_q == '0) begin
                        // Divide by zero reports the raw restoring result.
                        hi_q <= core_rem;
                        lo_q <= core_quo;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign req_ready = (state_q == ST_IDLE);
    assign hi_rdata  = hi_q;
    assign lo_rdata  = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: vector table plus flush and back-pressure sequences.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = 3'd0;
    logic [XLEN-1:0] req_src1 = '0;
    logic [XLEN-1:0] req_src2 = '0;
    logic            flush = 1'b0;
    logic            busy;
    logic [XLEN-1:0] hi_rdata, lo_rdata;

    int n_vec  = 0;
    int n_fail = 0;

    mdu_hilo dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .flush     (flush),
        .busy      (busy),
        .hi_rdata  (hi_rdata),
        .lo_rdata  (lo_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = v.op; req_src1 = v.a; req_src2 = v.b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle(n);
        check($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
        check($sformatf("v%0d hi", idx), 64'(hi_rdata), 64'(v.hi));
        check($sformatf("v%0d lo", idx), 64'(lo_rdata), 64'(v.lo));
        check($sformatf("v%0d ready", idx), 64'(req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0]  = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        tbl[1]  = '{OP_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[2]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        tbl[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MUL_LAT};
        tbl[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        tbl[5]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DIV_LAT};
        tbl[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        tbl[7]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, DIV_LAT};
        tbl[8]  = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000000, 32'h00000015, MUL_LAT};
        tbl[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
        tbl[10] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
        tbl[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
        tbl[12] = '{OP_MTHI,  32'h0000000A, 32'h0,        32'h0000000A, 32'h00000000, 0};
        tbl[13] = '{OP_MTLO,  32'h0000000B, 32'h0,        32'h0000000A, 32'h0000000B, 0};

        // Reset held with a live request: the request must be ignored.
        req_valid = 1'b1; req_op = OP_MTHI; req_src1 = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        check("reset hi", 64'(hi_rdata), 64'h0);
        check("reset lo", 64'(lo_rdata), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset ready", 64'(req_ready), 64'h1);

        for (int i = 0; i < 14; i++) apply(i, tbl[i]);

        // Flush at iteration 10 of DIVU 100/3.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd100; req_src2 = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check("flush busy", 64'(busy), 64'h0);
        check("flush ready", 64'(req_ready), 64'h1);
        check("flush hi", 64'(hi_rdata), 64'hA);
        check("flush lo", 64'(lo_rdata), 64'hB);
        @(negedge clk); flush = 1'b0;

        // Flush during FIX suppresses the write.
        req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd7; req_src2 = 32'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (XLEN) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check("fixflush busy", 64'(busy), 64'h0);
        check("fixflush hi", 64'(hi_rdata), 64'hA);
        check("fixflush lo", 64'(lo_rdata), 64'hB);

        // Flush together with a request drops it.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MTHI; req_src1 = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("reqflush hi", 64'(hi_rdata), 64'hA);

        apply(14, '{OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, MUL_LAT});

        // MTLO held valid throughout a busy DIV lands after the DIV write.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'hFFFFFFF9; req_src2 = 32'd2;
        @(posedge clk); #1;
        req_op = OP_MTLO; req_src1 = 32'h77;
        wait_idle(n);
        check("hold latency", 64'(n), 64'(DIV_LAT));
        check("hold div lo", 64'(lo_rdata), 64'hFFFFFFFD);
        check("hold div hi", 64'(hi_rdata), 64'hFFFFFFFF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("hold mtlo lo", 64'(lo_rdata), 64'h77);
        check("hold mtlo hi", 64'(hi_rdata), 64'hFFFFFFFF);
        check("hold busy", 64'(busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
